// File: rtl/dht11_pkg.sv
// -----------------------------------------------------------------------------
// dht11_pkg
// Shared definitions for the DHT11 sensor slice: the poll scheduler state
// encoding, the microsecond-to-millisecond ratio and the default timing
// constants that both dht11_poll_scheduler and dht11_controller start from.
// No ports.
// -----------------------------------------------------------------------------
package dht11_pkg;

    localparam int US_PER_MS = 1000;

    // Default scheduler timing, all in milliseconds unless noted.
    localparam int DEF_POLL_MS     = 2000;
    localparam int DEF_WAIT_MS     = 50;
    localparam int DEF_MIN_GAP_MS  = 1000;
    localparam int DEF_STALE_POLLS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } schedState_t;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_poll_scheduler_if.sv
// -----------------------------------------------------------------------------
// dht11_poll_scheduler_if
// Bundles every non-clock signal of dht11_poll_scheduler.
//   master : scheduler side (drives o*, receives i*)
//   slave  : environment side (controller model, tick source, consumers)
// Signals:
//   iTickUs    1  1us pulse          iEnable  1  auto polling enable
//   iForce     1  forced read req    oStart   1  start pulse to controller
//   iHumInt    8  controller hum     iTempInt 8  controller temp
//   iDataValid 1  controller valid   oHum/oTemp 8 last good reading
//   oFresh     1  update pulse       oBusy    1  transaction in flight
//   oStale     1  data stale         oErrCnt  8  saturating failure count
// Build option DHT_MINMAX_EN adds iClrMinMax and oHumMin/oHumMax/oTempMin/
// oTempMax.
// -----------------------------------------------------------------------------
interface dht11_poll_scheduler_if;
    logic       iTickUs;
    logic       iEnable;
    logic       iForce;
    logic       oStart;
    logic [7:0] iHumInt;
    logic [7:0] iTempInt;
    logic       iDataValid;
    logic [7:0] oHum;
    logic [7:0] oTemp;
    logic       oFresh;
    logic       oBusy;
    logic       oStale;
    logic [7:0] oErrCnt;
`ifdef DHT_MINMAX_EN
    logic       iClrMinMax;
    logic [7:0] oHumMin;
    logic [7:0] oHumMax;
    logic [7:0] oTempMin;
    logic [7:0] oTempMax;
`endif

    modport master (
        input  iTickUs, iEnable, iForce, iHumInt, iTempInt, iDataValid,
        output oStart, oHum, oTemp, oFresh, oBusy, oStale, oErrCnt
`ifdef DHT_MINMAX_EN
        , input  iClrMinMax
        , output oHumMin, oHumMax, oTempMin, oTempMax
`endif
    );

    modport slave (
        output iTickUs, iEnable, iForce, iHumInt, iTempInt, iDataValid,
        input  oStart, oHum, oTemp, oFresh, oBusy, oStale, oErrCnt
`ifdef DHT_MINMAX_EN
        , output iClrMinMax
        , input  oHumMin, oHumMax, oTempMin, oTempMax
`endif
    );

endinterface

// File: rtl/dht11_ms_tick.sv
// -----------------------------------------------------------------------------
// dht11_ms_tick
// Divides the 1us tick by US_PER_MS into a registered one-cycle ms pulse.
// Ports:
//   iClk      in  system clock
//   iRst      in  asynchronous active-high reset
//   iTickUs   in  one-cycle pulse every 1us
//   oMsPulse  out one-cycle pulse every US_PER_MS ticks
// -----------------------------------------------------------------------------
module dht11_ms_tick
    import dht11_pkg::*;
(
    input  logic iClk,
    input  logic iRst,
    input  logic iTickUs,
    output logic oMsPulse
);

    localparam int CW = $clog2(US_PER_MS);
    localparam logic [CW-1:0] LAST = CW'(US_PER_MS - 1);

    logic [CW-1:0] usCnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            usCnt    <= '0;
            oMsPulse <= 1'b0;
        end else begin
            oMsPulse <= 1'b0;
            if (iTickUs) begin
                if (usCnt == LAST) begin
                    usCnt    <= '0;
                    oMsPulse <= 1'b1;
                end else begin
                    usCnt <= usCnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dht11_poll_scheduler.sv
// -----------------------------------------------------------------------------
// dht11_poll_scheduler
// Issues periodic or forced one-cycle start pulses to dht11_controller, waits
// for its result with a timeout, keeps the last good humidity/temperature,
// counts failed reads and flags stale data.
// Ports:
//   iClk  in  system clock
//   iRst  in  asynchronous active-high reset
//   bus   dht11_poll_scheduler_if.master (see interface header)
// Build option DHT_MINMAX_EN: running min/max of humidity and temperature,
// reset to min=FF/max=00, cleared to the current reading by iClrMinMax.
//
// state    | meaning
// ST_IDLE  | waiting for min gap plus a pending force or an auto poll due
// ST_START | oStart high this cycle; gap/period/wait counters restart
// ST_WAIT  | waiting for a valid rising edge or the WAIT_MS timeout
// -----------------------------------------------------------------------------
module dht11_poll_scheduler
    import dht11_pkg::*;
#(
    parameter int POLL_MS     = DEF_POLL_MS,
    parameter int WAIT_MS     = DEF_WAIT_MS,
    parameter int MIN_GAP_MS  = DEF_MIN_GAP_MS,
    parameter int STALE_POLLS = DEF_STALE_POLLS
) (
    input  logic                   iClk,
    input  logic                   iRst,
    dht11_poll_scheduler_if.master bus
);

    localparam int GAP_W  = $clog2(MIN_GAP_MS + 1);
    localparam int PER_W  = $clog2(POLL_MS + 1);
    localparam int WAIT_W = $clog2(WAIT_MS + 1);
    localparam int STRK_W = $clog2(STALE_POLLS + 1);

    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_GAP_MS);
    localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(POLL_MS);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_MS);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STALE_POLLS);

    logic msPulse;

    dht11_ms_tick uMsTick (
        .iClk     (iClk),
        .iRst     (iRst),
        .iTickUs  (bus.iTickUs),
        .oMsPulse (msPulse)
    );

    schedState_t        state;
    logic [GAP_W-1:0]   gapCnt;
    logic [PER_W-1:0]   periodCnt;
    logic [WAIT_W-1:0]  waitCnt;
    logic [STRK_W-1:0]  streak;
    logic [STRK_W-1:0]  streakNext;
    logic               validQ;
    logic               validRise;
    logic               forcePend;
    logic               polledOnce;
    logic               startReq;
    logic               latchGood;

    logic       startR;
    logic       freshR;
    logic       busyR;
    logic       staleR;
    logic [7:0] humR;
    logic [7:0] tempR;
    logic [7:0] errCntR;

    assign validRise  = bus.iDataValid & ~validQ;
    assign latchGood  = (state == ST_WAIT) && validRise;
    assign streakNext = (streak == STRK_MAX) ? streak : streak + STRK_W'(1);

    // Until the first start after reset the period is treated as elapsed, so
    // the first auto poll waits only for the minimum gap.
    assign startReq = (gapCnt == GAP_MAX) &&
                      (forcePend ||
                       (bus.iEnable && (!polledOnce || periodCnt == PER_MAX)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            gapCnt     <= '0;
            periodCnt  <= '0;
            waitCnt    <= '0;
            streak     <= '0;
            validQ     <= 1'b1;  // a level held through reset is not new data
            forcePend  <= 1'b0;
            polledOnce <= 1'b0;
            startR     <= 1'b0;
            freshR     <= 1'b0;
            busyR      <= 1'b0;
            staleR     <= 1'b1;
            humR       <= 8'h00;
            tempR      <= 8'h00;
            errCntR    <= 8'h00;
        end else begin
            validQ <= bus.iDataValid;
            startR <= 1'b0;
            freshR <= 1'b0;

            if (msPulse) begin
                if (gapCnt != GAP_MAX) gapCnt <= gapCnt + GAP_W'(1);
                if (periodCnt != PER_MAX) periodCnt <= periodCnt + PER_W'(1);
                if (state == ST_WAIT && waitCnt != WAIT_MAX)
                    waitCnt <= waitCnt + WAIT_W'(1);
            end

            if (bus.iForce) forcePend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (startReq) begin
                        state      <= ST_START;
                        startR     <= 1'b1;
                        busyR      <= 1'b1;
                        polledOnce <= 1'b1;
                        // A force arriving in this very cycle stays pending.
                        forcePend  <= bus.iForce;
                    end
                end
                ST_START: begin
                    gapCnt    <= '0;
                    periodCnt <= '0;
                    waitCnt   <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Valid edge has priority over a timeout in the same cycle.
                    if (validRise) begin
                        humR   <= bus.iHumInt;
                        tempR  <= bus.iTempInt;
                        freshR <= 1'b1;
                        streak <= '0;
                        staleR <= 1'b0;
                        busyR  <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (waitCnt == WAIT_MAX) begin
                        errCntR <= satInc8(errCntR);
                        streak  <= streakNext;
                        if (streakNext == STRK_MAX) staleR <= 1'b1;
                        busyR   <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busyR <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oStart  = startR;
    assign bus.oFresh  = freshR;
    assign bus.oBusy   = busyR;
    assign bus.oStale  = staleR;
    assign bus.oHum    = humR;
    assign bus.oTemp   = tempR;
    assign bus.oErrCnt = errCntR;

`ifdef DHT_MINMAX_EN
    logic [7:0] humMin, humMax, tempMin, tempMax;
    logic [7:0] humNow, tempNow;

    // A clear coinciding with a good read reloads from the new reading.
    assign humNow  = latchGood ? bus.iHumInt  : humR;
    assign tempNow = latchGood ? bus.iTempInt : tempR;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            humMin  <= 8'hFF;
            humMax  <= 8'h00;
            tempMin <= 8'hFF;
            tempMax <= 8'h00;
        end else if (bus.iClrMinMax) begin
            humMin  <= humNow;
            humMax  <= humNow;
            tempMin <= tempNow;
            tempMax <= tempNow;
        end else if (latchGood) begin
            if (bus.iHumInt  < humMin)  humMin  <= bus.iHumInt;
            if (bus.iHumInt  > humMax)  humMax  <= bus.iHumInt;
            if (bus.iTempInt < tempMin) tempMin <= bus.iTempInt;
            if (bus.iTempInt > tempMax) tempMax <= bus.iTempInt;
        end
    end

    assign bus.oHumMin  = humMin;
    assign bus.oHumMax  = humMax;
    assign bus.oTempMin = tempMin;
    assign bus.oTempMax = tempMax;
`endif

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dht11_poll_scheduler
// Directed bench for dht11_poll_scheduler with POLL_MS=5, WAIT_MS=3,
// MIN_GAP_MS=2, STALE_POLLS=2 and a 1us tick every clock (1ms = 1000 cycles).
// The min/max section is compiled only with DHT_MINMAX_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dht11_poll_scheduler;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    dht11_poll_scheduler_if bus();

    dht11_poll_scheduler #(
        .POLL_MS     (5),
        .WAIT_MS     (3),
        .MIN_GAP_MS  (2),
        .STALE_POLLS (2)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    int startCnt = 0;
    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if (bus.oStart === 1'b1) startCnt <= startCnt + 1;
    end

    int nChk  = 0;
    int nFail = 0;

    typedef struct {
        bit         respond;
        logic [7:0] h;
        logic [7:0] t;
        logic [7:0] expH;
        logic [7:0] expT;
        logic [7:0] expErr;
        logic       expStale;
    } vec_t;

    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_start(input int maxCyc, output int tStart);
        int n = 0;
        while (bus.oStart !== 1'b1 && n < maxCyc) begin
            tick(1);
            n++;
        end
        check("start_seen", {31'd0, bus.oStart}, 1);
        tStart = cyc;
    endtask

    // Forced read answered 100 cycles after the start pulse.
    task automatic force_read(input logic [7:0] h, input logic [7:0] t);
        int tS;
        bus.iForce = 1'b1;
        tick(1);
        bus.iForce = 1'b0;
        wait_start(4000, tS);
        wait_until(tS + 100);
        bus.iHumInt    = h;
        bus.iTempInt   = t;
        bus.iDataValid = 1'b1;
        tick(1);
        check("force_fresh", {31'd0, bus.oFresh}, 1);
        check("force_hum", {24'd0, bus.oHum}, {24'd0, h});
        tick(1);
        bus.iDataValid = 1'b0;
    endtask

    int tS, tPrev, tF;

    initial begin
        vecs[0] = '{1'b1, 8'd55, 8'd24, 8'd55, 8'd24, 8'd0, 1'b0};
        vecs[1] = '{1'b0, 8'd0,  8'd0,  8'd55, 8'd24, 8'd1, 1'b0};
        vecs[2] = '{1'b0, 8'd0,  8'd0,  8'd55, 8'd24, 8'd2, 1'b1};
        vecs[3] = '{1'b1, 8'd40, 8'd20, 8'd40, 8'd20, 8'd2, 1'b0};

        bus.iTickUs    = 1'b1;
        bus.iEnable    = 1'b0;
        bus.iForce     = 1'b0;
        bus.iHumInt    = 8'd0;
        bus.iTempInt   = 8'd0;
        bus.iDataValid = 1'b0;
`ifdef DHT_MINMAX_EN
        bus.iClrMinMax = 1'b0;
`endif

        // Reset values
        tick(3);
        check("rst_start", {31'd0, bus.oStart}, 0);
        check("rst_busy",  {31'd0, bus.oBusy},  0);
        check("rst_stale", {31'd0, bus.oStale}, 1);
        check("rst_err",   {24'd0, bus.oErrCnt}, 0);
        check("rst_hum",   {24'd0, bus.oHum},   0);
        iRst = 1'b0;
        bus.iEnable = 1'b1;

        // Auto polls: good, silent, silent, good
        tPrev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start(6000, tS);
            if (i > 0) check("poll_period", tS - tPrev, 5000);
            tPrev = tS;
            tick(1);
            check("start_one_cycle", {31'd0, bus.oStart}, 0);
            check("busy_in_wait", {31'd0, bus.oBusy}, 1);
            if (vecs[i].respond) begin
                wait_until(tS + 1000);
                bus.iHumInt    = vecs[i].h;
                bus.iTempInt   = vecs[i].t;
                bus.iDataValid = 1'b1;
                tick(1);
                check("fresh_pulse", {31'd0, bus.oFresh}, 1);
                tick(1);
                check("fresh_once", {31'd0, bus.oFresh}, 0);
                bus.iDataValid = 1'b0;
            end else begin
                wait_until(tS + 2999);
                check("busy_before_timeout", {31'd0, bus.oBusy}, 1);
                tick(1);
                check("busy_after_timeout", {31'd0, bus.oBusy}, 0);
            end
            check("vec_hum",   {24'd0, bus.oHum},    {24'd0, vecs[i].expH});
            check("vec_temp",  {24'd0, bus.oTemp},   {24'd0, vecs[i].expT});
            check("vec_err",   {24'd0, bus.oErrCnt}, {24'd0, vecs[i].expErr});
            check("vec_stale", {31'd0, bus.oStale},  {31'd0, vecs[i].expStale});
        end
        check("auto_start_count", startCnt, 4);

        // Force 1ms after last start with auto off: start held until 2ms gap
        bus.iEnable = 1'b0;
        bus.iForce  = 1'b1;
        tick(1);
        bus.iForce  = 1'b0;
        wait_start(3000, tF);
        check("force_gap_time", tF - tPrev, 2000);

        // Valid edge lands in the cycle the wait counter reaches WAIT_MS
        wait_until(tF + 2999);
        check("busy_edge_race", {31'd0, bus.oBusy}, 1);
        bus.iHumInt    = 8'd66;
        bus.iTempInt   = 8'd77;
        bus.iDataValid = 1'b1;
        tick(1);
        check("race_fresh", {31'd0, bus.oFresh}, 1);
        check("race_hum",   {24'd0, bus.oHum},    66);
        check("race_temp",  {24'd0, bus.oTemp},   77);
        check("race_err",   {24'd0, bus.oErrCnt}, 2);
        check("race_busy",  {31'd0, bus.oBusy},   0);
        tick(1);
        bus.iDataValid = 1'b0;

        // No auto polls while disabled
        tick(6000);
        check("no_auto_polls", startCnt, 5);

`ifdef DHT_MINMAX_EN
        bus.iClrMinMax = 1'b1;
        tick(1);
        bus.iClrMinMax = 1'b0;
        check("mm_clr_min0", {24'd0, bus.oHumMin}, 66);
        force_read(8'd30, 8'd20);
        force_read(8'd50, 8'd25);
        force_read(8'd40, 8'd22);
        check("mm_hum_min",  {24'd0, bus.oHumMin},  30);
        check("mm_hum_max",  {24'd0, bus.oHumMax},  50);
        check("mm_temp_min", {24'd0, bus.oTempMin}, 20);
        check("mm_temp_max", {24'd0, bus.oTempMax}, 25);
        bus.iClrMinMax = 1'b1;
        tick(1);
        bus.iClrMinMax = 1'b0;
        check("mm_clr_hmin", {24'd0, bus.oHumMin},  40);
        check("mm_clr_hmax", {24'd0, bus.oHumMax},  40);
        check("mm_clr_tmin", {24'd0, bus.oTempMin}, 22);
        check("mm_clr_tmax", {24'd0, bus.oTempMax}, 22);
`else
        force_read(8'd40, 8'd22);
`endif

        // Reset in the middle of a transaction, valid held high across it
        bus.iForce = 1'b1;
        tick(1);
        bus.iForce = 1'b0;
        wait_start(4000, tS);
        wait_until(tS + 500);
        iRst = 1'b1;
        bus.iDataValid = 1'b1;
        #1;
        check("mid_rst_busy",  {31'd0, bus.oBusy},   0);
        check("mid_rst_stale", {31'd0, bus.oStale},  1);
        check("mid_rst_hum",   {24'd0, bus.oHum},    0);
        check("mid_rst_err",   {24'd0, bus.oErrCnt}, 0);
        check("mid_rst_start", {31'd0, bus.oStart},  0);
        tick(2);
        iRst = 1'b0;
        bus.iEnable = 1'b1;
        wait_start(4000, tS);
        wait_until(tS + 2999);
        check("held_valid_no_edge", {31'd0, bus.oBusy}, 1);
        tick(1);
        check("held_valid_timeout", {24'd0, bus.oErrCnt}, 1);
        check("held_valid_hum",     {24'd0, bus.oHum},    0);
        check("held_valid_stale",   {31'd0, bus.oStale},  1);
        bus.iEnable    = 1'b0;
        bus.iDataValid = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
